// File: rtl/mmu_pkg.sv
// mmu_pkg -- shared definitions for the banked MMU.
//   Register offsets on the 5-bit register select, CTRL/STATUS bit
//   positions, and the functions that derive the window/page widths from
//   NUM_WIN and PHYS_W.
package mmu_pkg;

  localparam logic [4:0] REG_CTRL   = 5'd0;
  localparam logic [4:0] REG_EN     = 5'd1;
  localparam logic [4:0] REG_WP     = 5'd2;
  localparam logic [4:0] REG_STATUS = 5'd3;
  localparam logic [4:0] REG_COMMIT = 5'd4;
  localparam logic [4:0] REG_STAGE  = 5'd8;   // STAGE[i] lives at REG_STAGE + i

  localparam int CTRL_MAP_EN      = 0;
  localparam int CTRL_AUTO_COMMIT = 1;
  localparam int CTRL_IRQ_EN      = 2;

  localparam int STAT_FAULT   = 0;
  localparam int STAT_OVF     = 1;
  localparam int STAT_CLR     = 0;  // write 1 here to clear fault and ovf
  localparam int STAT_WIN_LSB = 4;  // fault_win occupies [7:4]

  // Number of logical address bits that select a window.
  function automatic int win_bits(input int num_win);
    return $clog2(num_win);
  endfunction

  // Width of the in-window offset of the 16-bit logical address.
  function automatic int win_w(input int num_win);
    return 16 - win_bits(num_win);
  endfunction

  // Width of the physical page number driven onto phys_page.
  function automatic int page_w(input int phys_w, input int num_win);
    return phys_w - win_w(num_win);
  endfunction

endpackage

// File: rtl/mmu_wr_edge.sv
// mmu_wr_edge -- one-shot strobe detector.
//   clk, reset_n : clock, asynchronous active-low reset
//   strobe       : level condition (e.g. cs_n=0 && wr_n=0)
//   pulse        : high during the cycle in which strobe is seen at a clock
//                  edge for the first time; the consumer acts on that edge.
// The detector must see strobe low at an edge before it arms. Reset leaves it
// disarmed, so a strobe still held through reset release is not mistaken for
// a fresh one.
module mmu_wr_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic pulse
);

  logic armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed <= 1'b0;
    else          armed <= !strobe;
  end

  assign pulse = strobe && armed;

endmodule

// File: rtl/mmu_banked.sv
// mmu_banked -- banked address-translation unit for a 16-bit CPU.
//   The logical space is split into NUM_WIN windows selected by addr_hi.
//   Each window has a staged and an active page register; the active set
//   drives phys_page, the staged set is what the CPU reads and writes.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   mreq_n,rd_n,wr_n  CPU memory request and strobes (active-low levels)
//   cs_n, rs          register-file select and register offset
//   addr_hi           logical address bits [15:WIN_W]
//   data_in/data_out  register write data / combinational read data
//   data_oe           read-data drive enable (cs_n=0 and rd_n=0)
//   phys_page         physical page bits [PHYS_W-1:WIN_W]
//   mem_wr_n          memory write strobe, blocked on protected windows
//   irq_n             registered, active-low fault interrupt
// Bus semantics: strobes are levels with no wait states. A register write
// (cs_n=0, wr_n=0) or a protected memory write is acted on exactly once, at
// the first rising edge that sees it; it must be released and reasserted to
// act again.
module mmu_banked
  import mmu_pkg::*;
#(
  parameter int NUM_WIN = 4,
  parameter int PHYS_W  = 20
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               mreq_n,
  input  logic                               rd_n,
  input  logic                               wr_n,
  input  logic                               cs_n,
  input  logic [4:0]                         rs,
  input  logic [$clog2(NUM_WIN)-1:0]         addr_hi,
  input  logic [7:0]                         data_in,
  output logic [7:0]                         data_out,
  output logic                               data_oe,
  output logic [page_w(PHYS_W, NUM_WIN)-1:0] phys_page,
  output logic                               mem_wr_n,
  output logic                               irq_n
);

  localparam int AW     = win_bits(NUM_WIN);
  localparam int PAGE_W = page_w(PHYS_W, NUM_WIN);

  logic               map_en, auto_commit, irq_en;
  logic [NUM_WIN-1:0] en_mask, wp_mask;
  logic [PAGE_W-1:0]  stage  [NUM_WIN];
  logic [PAGE_W-1:0]  active [NUM_WIN];
  logic               fault, ovf;
  logic [3:0]         fault_win;

  logic          reg_we, fault_hit;
  logic          win_mapped, prot_wr, status_clr, stage_hit;
  logic [4:0]    rs_off;
  logic [AW-1:0] stage_idx;
  logic [7:0]    status;

  assign rs_off     = rs - REG_STAGE;
  assign stage_hit  = (rs >= REG_STAGE) && (rs_off < 5'(NUM_WIN));
  assign stage_idx  = rs_off[AW-1:0];

  assign win_mapped = map_en && en_mask[addr_hi];
  assign prot_wr    = !mreq_n && !wr_n && win_mapped && wp_mask[addr_hi];
  assign status_clr = reg_we && (rs == REG_STATUS) && data_in[STAT_CLR];

  mmu_wr_edge u_reg_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (!cs_n && !wr_n),
    .pulse   (reg_we)
  );

  mmu_wr_edge u_fault_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (prot_wr),
    .pulse   (fault_hit)
  );

  // Register file. COMMIT reads STAGE through non-blocking semantics, so the
  // copy always uses the values present before the edge.
  // The mask registers sit on an 8-bit bus: with more than eight windows,
  // window i takes its enable/protect bit from data bit (i mod 8).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      map_en      <= 1'b0;
      auto_commit <= 1'b0;
      irq_en      <= 1'b0;
      en_mask     <= '0;
      wp_mask     <= '0;
      for (int i = 0; i < NUM_WIN; i++) begin
        stage[i]  <= '0;
        active[i] <= '0;
      end
    end else if (reg_we) begin
      case (rs)
        REG_CTRL: begin
          map_en      <= data_in[CTRL_MAP_EN];
          auto_commit <= data_in[CTRL_AUTO_COMMIT];
          irq_en      <= data_in[CTRL_IRQ_EN];
        end
        REG_EN: for (int i = 0; i < NUM_WIN; i++) en_mask[i] <= data_in[i % 8];
        REG_WP: for (int i = 0; i < NUM_WIN; i++) wp_mask[i] <= data_in[i % 8];
        REG_COMMIT: for (int i = 0; i < NUM_WIN; i++) active[i] <= stage[i];
        default: begin
          if (stage_hit) begin
            stage[stage_idx] <= PAGE_W'(data_in);
            if (auto_commit) active[stage_idx] <= PAGE_W'(data_in);
          end
        end
      endcase
    end
  end

  // Fault capture. A new fault outranks a simultaneous clear; a repeat fault
  // while one is pending only flags overflow and keeps the first window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault     <= 1'b0;
      ovf       <= 1'b0;
      fault_win <= 4'h0;
      irq_n     <= 1'b1;
    end else begin
      if (fault_hit) begin
        if (fault && !status_clr) begin
          ovf <= 1'b1;
        end else begin
          fault     <= 1'b1;
          ovf       <= 1'b0;
          fault_win <= 4'(addr_hi);
        end
      end else if (status_clr) begin
        fault <= 1'b0;
        ovf   <= 1'b0;
      end
      irq_n <= !(fault && irq_en);
    end
  end

  always_comb begin
    status                        = 8'h00;
    status[STAT_FAULT]            = fault;
    status[STAT_OVF]              = ovf;
    status[STAT_WIN_LSB +: 4]     = fault_win;
  end

  always_comb begin
    data_out = 8'h00;
    case (rs)
      REG_CTRL: begin
        data_out[CTRL_MAP_EN]      = map_en;
        data_out[CTRL_AUTO_COMMIT] = auto_commit;
        data_out[CTRL_IRQ_EN]      = irq_en;
      end
      REG_EN:     data_out = 8'(en_mask);
      REG_WP:     data_out = 8'(wp_mask);
      REG_STATUS: data_out = status;
      default:    if (stage_hit) data_out = 8'(stage[stage_idx]);
    endcase
  end

  // Unmapped windows pass the logical window number straight through.
  always_comb begin
    phys_page = '0;
    if (!mreq_n) begin
      if (win_mapped) phys_page = active[addr_hi];
      else            phys_page = PAGE_W'(addr_hi);
    end
  end

  assign mem_wr_n = prot_wr ? 1'b1 : wr_n;
  assign data_oe  = !cs_n && !rd_n;

endmodule

// File: tb/tb_mmu_banked.sv
// tb_mmu_banked -- directed bench for mmu_banked.
//   u_dut   : default parameters (4 windows, 6-bit page)
//   u_dut16 : 16 windows, PHYS_W=20 (8-bit page)
// Both share clock, reset and the CPU bus; each has its own addr_hi.
module tb_mmu_banked;

  logic       clk;
  logic       reset_n;
  logic       mreq_n, rd_n, wr_n, cs_n;
  logic [4:0] rs;
  logic [1:0] addr_hi;
  logic [3:0] addr_hi16;
  logic [7:0] data_in;

  logic [7:0] data_out, data_out16;
  logic       data_oe, data_oe16;
  logic [5:0] phys_page;
  logic [7:0] phys_page16;
  logic       mem_wr_n, mem_wr_n16;
  logic       irq_n, irq_n16;

  int errors = 0;
  int checks = 0;

  mmu_banked u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mreq_n    (mreq_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .cs_n      (cs_n),
    .rs        (rs),
    .addr_hi   (addr_hi),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .phys_page (phys_page),
    .mem_wr_n  (mem_wr_n),
    .irq_n     (irq_n)
  );

  mmu_banked #(.NUM_WIN(16), .PHYS_W(20)) u_dut16 (
    .clk       (clk),
    .reset_n   (reset_n),
    .mreq_n    (mreq_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .cs_n      (cs_n),
    .rs        (rs),
    .addr_hi   (addr_hi16),
    .data_in   (data_in),
    .data_out  (data_out16),
    .data_oe   (data_oe16),
    .phys_page (phys_page16),
    .mem_wr_n  (mem_wr_n16),
    .irq_n     (irq_n16)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // checker
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
  endtask

  // driver tasks
  task automatic bus_idle();
    cs_n = 1'b1;
    rd_n = 1'b1;
    wr_n = 1'b1;
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    rs = a; data_in = d; cs_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [7:0] exp,
                            input bit big);
    @(negedge clk);
    rs = a; cs_n = 1'b0; rd_n = 1'b0;
    #1;
    check(tag, big ? data_out16 : data_out, exp);
    bus_idle();
  endtask

  task automatic mem_write(input logic [1:0] w);
    @(negedge clk);
    mreq_n = 1'b0; addr_hi = w; wr_n = 1'b0;
    @(negedge clk);
    mreq_n = 1'b1; wr_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus_idle();
    mreq_n = 1'b1; rs = 5'd0; addr_hi = 2'd0; addr_hi16 = 4'd0; data_in = 8'h00;

    // reset state
    #12;
    check("rst_phys", 8'(phys_page), 8'h00);
    check("rst_phys16", phys_page16, 8'h00);
    check("rst_mem_wr_n", 8'(mem_wr_n), 8'h01);
    check("rst_irq_n", 8'(irq_n), 8'h01);
    check("rst_data_oe", 8'(data_oe), 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    read_check("rst_ctrl", 5'd0, 8'h00, 1'b0);
    read_check("rst_status", 5'd3, 8'h00, 1'b0);

    // pass-through with mapping disabled
    @(negedge clk);
    mreq_n = 1'b0; addr_hi = 2'd2; #1;
    check("pass_phys_w2", 8'(phys_page), 8'h02);
    check("pass_mem_wr_n_hi", 8'(mem_wr_n), 8'h01);
    wr_n = 1'b0; #1;
    check("pass_mem_wr_n_lo", 8'(mem_wr_n), 8'h00);
    wr_n = 1'b1; mreq_n = 1'b1; #1;
    check("idle_phys_zero", 8'(phys_page), 8'h00);

    // staged write, then explicit COMMIT
    reg_write(5'd9, 8'h2A);
    mreq_n = 1'b0; addr_hi = 2'd1; #1;
    check("stage_only_unmapped", 8'(phys_page), 8'h01);
    mreq_n = 1'b1;
    reg_write(5'd0, 8'h01);
    reg_write(5'd1, 8'h02);
    mreq_n = 1'b0; addr_hi = 2'd1; #1;
    check("mapped_pre_commit", 8'(phys_page), 8'h00);
    mreq_n = 1'b1;
    @(negedge clk);
    rs = 5'd9; cs_n = 1'b0; rd_n = 1'b0; #1;
    check("stage1_read", data_out, 8'h2A);
    check("data_oe_read", 8'(data_oe), 8'h01);
    bus_idle();
    reg_write(5'd4, 8'h5A);
    mreq_n = 1'b0; addr_hi = 2'd1; #1;
    check("post_commit", 8'(phys_page), 8'h2A);
    mreq_n = 1'b1;

    // auto-commit takes effect on the write edge itself
    reg_write(5'd1, 8'h08);
    reg_write(5'd0, 8'h03);
    @(negedge clk);
    rs = 5'd11; data_in = 8'h15; cs_n = 1'b0; wr_n = 1'b0;
    mreq_n = 1'b0; addr_hi = 2'd3; #1;
    check("auto_before_edge", 8'(phys_page), 8'h00);
    @(posedge clk); #1;
    check("auto_after_edge", 8'(phys_page), 8'h15);
    @(negedge clk);
    bus_idle(); mreq_n = 1'b1;
    read_check("stage3_read", 5'd11, 8'h15, 1'b0);

    // write protection, fault, irq, overflow
    reg_write(5'd0, 8'h05);
    reg_write(5'd1, 8'h01);
    reg_write(5'd2, 8'h01);
    @(negedge clk);
    mreq_n = 1'b0; addr_hi = 2'd0; wr_n = 1'b0; #1;
    check("wp_mem_wr_n", 8'(mem_wr_n), 8'h01);
    @(negedge clk);
    rs = 5'd3; #1;
    check("fault_status", data_out, 8'h01);
    check("irq_not_yet", 8'(irq_n), 8'h01);
    @(posedge clk); #1;
    check("irq_low", 8'(irq_n), 8'h00);
    check("held_no_ovf", data_out, 8'h01);
    @(negedge clk);
    wr_n = 1'b1; mreq_n = 1'b1;
    mem_write(2'd0);
    read_check("ovf_status", 5'd3, 8'h03, 1'b0);
    @(negedge clk);
    mreq_n = 1'b0; addr_hi = 2'd1; wr_n = 1'b0; #1;
    check("unprot_mem_wr_n", 8'(mem_wr_n), 8'h00);
    @(negedge clk);
    wr_n = 1'b1; mreq_n = 1'b1;

    // status clear, irq release
    reg_write(5'd3, 8'h01);
    read_check("status_cleared", 5'd3, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("irq_release", 8'(irq_n), 8'h01);

    // strobe held for five edges produces a single write
    @(negedge clk);
    rs = 5'd8; data_in = 8'h11; cs_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    data_in = 8'h22;
    repeat (4) @(negedge clk);
    bus_idle();
    read_check("held_write_once", 5'd8, 8'h11, 1'b0);
    reg_write(5'd4, 8'h00);
    mreq_n = 1'b0; addr_hi = 2'd0; #1;
    check("held_commit_phys", 8'(phys_page), 8'h11);
    mreq_n = 1'b1;

    // clear coincident with a new fault on window 2
    reg_write(5'd1, 8'h05);
    reg_write(5'd2, 8'h05);
    mem_write(2'd0);
    mem_write(2'd0);
    read_check("pre_coincide_status", 5'd3, 8'h03, 1'b0);
    @(negedge clk);
    rs = 5'd3; data_in = 8'h01; cs_n = 1'b0; wr_n = 1'b0;
    mreq_n = 1'b0; addr_hi = 2'd2; #1;
    check("coincide_mem_wr_n", 8'(mem_wr_n), 8'h01);
    @(negedge clk);
    bus_idle(); mreq_n = 1'b1;
    read_check("coincide_status", 5'd3, 8'h21, 1'b0);

    // reserved offsets and unused bits
    reg_write(5'd5, 8'hFF);
    read_check("reserved5", 5'd5, 8'h00, 1'b0);
    read_check("unimpl_stage4", 5'd12, 8'h00, 1'b0);
    read_check("commit_reads0", 5'd4, 8'h00, 1'b0);
    reg_write(5'd0, 8'hFF);
    read_check("ctrl_upper0", 5'd0, 8'h07, 1'b0);
    reg_write(5'd1, 8'hFF);
    read_check("en_upper0", 5'd1, 8'h0F, 1'b0);

    // 16-window sweep
    for (int i = 0; i < 16; i++) reg_write(5'(8 + i), 8'(8'h80 + 3 * i));
    reg_write(5'd0, 8'h05);
    reg_write(5'd4, 8'h00);
    read_check("stage15_read16", 5'd23, 8'hAD, 1'b1);
    read_check("en_read16", 5'd1, 8'hFF, 1'b1);
    @(negedge clk);
    mreq_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr_hi16 = 4'(i); #1;
      check($sformatf("sweep16_w%0d", i), phys_page16, 8'(8'h80 + 3 * i));
    end
    mreq_n = 1'b1;

    // asynchronous reset in the middle of a write cycle
    @(negedge clk);
    rs = 5'd0; data_in = 8'h01; cs_n = 1'b0; wr_n = 1'b0;
    mreq_n = 1'b0; addr_hi = 2'd0; addr_hi16 = 4'd5; #1;
    check("pre_rst_mem_wr_n", 8'(mem_wr_n), 8'h01);
    check("pre_rst_irq_n", 8'(irq_n), 8'h00);
    check("pre_rst_phys16", phys_page16, 8'h8F);
    #1 reset_n = 1'b0;
    #1;
    check("async_mem_wr_n", 8'(mem_wr_n), 8'h00);
    check("async_irq_n", 8'(irq_n), 8'h01);
    check("async_irq_n16", 8'(irq_n16), 8'h01);
    check("async_phys", 8'(phys_page), 8'h00);
    check("async_phys16", phys_page16, 8'h05);
    check("async_ctrl", data_out, 8'h00);
    check("async_ctrl16", data_out16, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("held_after_rst", data_out, 8'h00);
    @(negedge clk);
    bus_idle(); mreq_n = 1'b1;
    reg_write(5'd0, 8'h01);
    read_check("rearm_write", 5'd0, 8'h01, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
